// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: decodes multiplexed active-low 7-segment scan back into 8-digit code frames
module seg7_scan_decoder #(
  parameter int NUM_DIGITS     = 8,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [6:0]              seg,
  input  logic                    dp,
  output logic [4*NUM_DIGITS-1:0] frame_digits,
  output logic [NUM_DIGITS-1:0]   frame_dp,
  output logic                    frame_valid,
  output logic                    frame_unknown,
  output logic                    frame_error,
  output logic                    scan_active
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, SYNC, COLLECT} state_t;
  state_t                  state;
  logic [NUM_DIGITS-1:0]   an_m, an_q, seen, seen_n, sh_dp;
  logic [6:0]              seg_m, seg_q, seg_p;
  logic                    dp_m, dp_q, dp_p;
  logic [IW-1:0]           idx, idx_p;
  logic [SW-1:0]           cnt;
  logic [TW-1:0]           tcnt;
  logic [4*NUM_DIGITS-1:0] sh_d;
  logic [3:0]              code;
  logic                    sel, multi, multi_q, changed, cap, pub, tout, unk;
  function automatic logic [3:0] decode(input logic [6:0] s);
    case (s)
      7'h40:   decode = 4'h0;
      7'h79:   decode = 4'h1;
      7'h24:   decode = 4'h2;
      7'h30:   decode = 4'h3;
      7'h19:   decode = 4'h4;
      7'h12:   decode = 4'h5;
      7'h02:   decode = 4'h6;
      7'h78:   decode = 4'h7;
      7'h00:   decode = 4'h8;
      7'h10:   decode = 4'h9;
      7'h08:   decode = 4'hA;
      7'h47:   decode = 4'hB;
      7'h09:   decode = 4'hD;
      7'h7F:   decode = 4'hF;
      default: decode = 4'hE;
    endcase
  endfunction
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (!an_q[i]) idx = IW'(i);
  end
  always_comb begin
    unk = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++)
      unk = unk | (sh_d[4*i +: 4] == 4'hE);
  end
  assign sel     = $onehot(~an_q);
  assign multi   = !sel && an_q != '1;
  assign changed = idx != idx_p || seg_q != seg_p || dp_q != dp_p;
  assign cap     = sel && !changed && cnt == SW'(SETTLE_CYCLES - 1);
  assign tout    = tcnt == TW'(TIMEOUT_CYCLES - 1);
  assign seen_n  = seen | (NUM_DIGITS'(1) << idx);
  assign code    = decode(seg_q);
  always_ff @(posedge clk) begin
    if (rst) begin
      an_m          <= '1;
      an_q          <= '1;
      seg_m         <= '1;
      seg_q         <= '1;
      seg_p         <= '1;
      dp_m          <= 1'b1;
      dp_q          <= 1'b1;
      dp_p          <= 1'b1;
      idx_p         <= '0;
      multi_q       <= 1'b0;
      cnt           <= '0;
      tcnt          <= '0;
      state         <= IDLE;
      seen          <= '0;
      pub           <= 1'b0;
      sh_d          <= '1;
      sh_dp         <= '0;
      frame_digits  <= '1;
      frame_dp      <= '0;
      frame_unknown <= 1'b0;
      frame_valid   <= 1'b0;
      frame_error   <= 1'b0;
      scan_active   <= 1'b0;
    end else begin
      an_m        <= an;
      an_q        <= an_m;
      seg_m       <= seg;
      seg_q       <= seg_m;
      seg_p       <= seg_q;
      dp_m        <= dp;
      dp_q        <= dp_m;
      dp_p        <= dp_q;
      idx_p       <= idx;
      multi_q     <= multi;
      cnt         <= (!sel || changed) ? '0 : (cnt == SW'(SETTLE_CYCLES) ? cnt : cnt + 1'b1);
      tcnt        <= cap ? '0 : (tout ? tcnt : tcnt + 1'b1);
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      pub         <= 1'b0;
      if (state == IDLE) begin
        if (cap) begin
          state       <= SYNC;
          scan_active <= 1'b1;
        end
      end else if (multi && !multi_q) begin
        frame_error <= 1'b1;
        seen        <= '0;
        state       <= SYNC;
      end else if (pub) begin
        frame_digits  <= sh_d;
        frame_dp      <= sh_dp;
        frame_unknown <= unk;
        frame_valid   <= 1'b1;
        seen          <= '0;
        state         <= SYNC;
      end else if (cap) begin
        sh_d[4*idx +: 4] <= code;
        sh_dp[idx]       <= !dp_q;
        if (state == SYNC) begin
          if (idx == '0) begin
            seen  <= NUM_DIGITS'(1);
            state <= COLLECT;
          end
        end else if (seen[idx]) begin
          frame_error <= 1'b1;
          seen        <= (idx == '0) ? NUM_DIGITS'(1) : '0;
          state       <= (idx == '0) ? COLLECT : SYNC;
        end else begin
          seen <= seen_n;
          pub  <= seen_n == '1;
        end
      end else if (tout) begin
        state       <= IDLE;
        scan_active <= 1'b0;
        seen        <= '0;
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed self-checking bench for seg7_scan_decoder
module tb_seg7_scan_decoder;
  localparam int T = 3000;
  localparam logic [6:0] SA = 7'h08, SH = 7'h09, SO = 7'h40, SL = 7'h47, SB = 7'h7F;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  an  = 8'hFF;
  logic [6:0]  seg = 7'h7F;
  logic        dp  = 1'b1;
  logic [31:0] frame_digits;
  logic [7:0]  frame_dp;
  logic        frame_valid, frame_unknown, frame_error, scan_active;
  int          passed = 0, total = 0, nvalid = 0, nerr = 0, nboth = 0, v0, e0;
  logic [6:0]  num [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [6:0]  aloha [8];
  logic [6:0]  p2 [8];
  logic [6:0]  p7 [8];
  always #5 clk = ~clk;
  seg7_scan_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .an(an), .seg(seg), .dp(dp),
    .frame_digits(frame_digits), .frame_dp(frame_dp), .frame_valid(frame_valid),
    .frame_unknown(frame_unknown), .frame_error(frame_error), .scan_active(scan_active)
  );
  always @(negedge clk) begin
    if (frame_valid) nvalid++;
    if (frame_error) nerr++;
    if (frame_valid && frame_error) nboth++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic dwell(input int i, input logic [6:0] s, input logic d, input int n);
    an  = ~(8'd1 << i);
    seg = s;
    dp  = d;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic scan(input logic [6:0] p [8], input logic [7:0] dpm, input int n, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) dwell(i, p[i], !dpm[i], n);
  endtask
  initial begin
    aloha = '{SA, SH, SO, SL, SA, SB, SB, SB};
    p2    = '{num[4], num[3], num[2], num[1], num[0], SB, SB, SB};
    p7    = aloha;
    p7[2] = 7'b0101010;
    repeat (3) @(posedge clk);
    #1;
    chk("rst digits", frame_digits, 32'hFFFF_FFFF);
    chk("rst dp", 32'(frame_dp), 32'h0);
    chk("rst unknown", 32'(frame_unknown), 32'h0);
    chk("rst valid", 32'(frame_valid), 32'h0);
    chk("rst error", 32'(frame_error), 32'h0);
    chk("rst active", 32'(scan_active), 32'h0);
    rst = 1'b0;
    v0 = nvalid;
    e0 = nerr;
    for (int k = 0; k < 3; k++) scan(aloha, 8'h00, 1000, 0, 7);
    chk("aloha valid count", 32'(nvalid - v0), 32'd2);
    chk("aloha digits", frame_digits, 32'hFFFA_B0DA);
    chk("aloha dp", 32'(frame_dp), 32'h0);
    chk("aloha unknown", 32'(frame_unknown), 32'h0);
    chk("aloha active", 32'(scan_active), 32'h1);
    chk("aloha errors", 32'(nerr - e0), 32'd0);
    v0 = nvalid;
    scan(p2, 8'h08, 40, 0, 7);
    chk("1234 valid count", 32'(nvalid - v0), 32'd1);
    chk("1234 digits", frame_digits, 32'hFFF0_1234);
    chk("1234 dp", 32'(frame_dp), 32'h08);
    v0 = nvalid;
    e0 = nerr;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) begin
        dwell(5, num[9], 1'b1, 5);
        dwell(5, num[4], 1'b1, 35);
      end else dwell(i, num[i], 1'b1, 40);
    end
    chk("settle valid count", 32'(nvalid - v0), 32'd1);
    chk("settle digits", frame_digits, 32'h7644_3210);
    chk("settle errors", 32'(nerr - e0), 32'd0);
    v0 = nvalid;
    e0 = nerr;
    scan(p2, 8'h00, 40, 0, 3);
    an = 8'b1111_1100;
    repeat (3) @(posedge clk);
    #1;
    scan(p2, 8'h00, 40, 4, 7);
    chk("multi errors", 32'(nerr - e0), 32'd1);
    chk("multi valid count", 32'(nvalid - v0), 32'd0);
    chk("multi digits held", frame_digits, 32'h7644_3210);
    scan(aloha, 8'h00, 40, 0, 7);
    chk("multi recover valid", 32'(nvalid - v0), 32'd1);
    chk("multi recover digits", frame_digits, 32'hFFFA_B0DA);
    v0 = nvalid;
    an = 8'hFF;
    repeat (T - 60) @(posedge clk);
    #1;
    chk("timeout before", 32'(scan_active), 32'h1);
    repeat (80) @(posedge clk);
    #1;
    chk("timeout after", 32'(scan_active), 32'h0);
    chk("timeout digits held", frame_digits, 32'hFFFA_B0DA);
    chk("timeout valid count", 32'(nvalid - v0), 32'd0);
    dwell(7, SB, 1'b1, 40);
    chk("resume active", 32'(scan_active), 32'h1);
    scan(aloha, 8'h00, 40, 0, 4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid rst digits", frame_digits, 32'hFFFF_FFFF);
    chk("mid rst dp", 32'(frame_dp), 32'h0);
    chk("mid rst active", 32'(scan_active), 32'h0);
    chk("mid rst valid", 32'(frame_valid), 32'h0);
    v0 = nvalid;
    scan(aloha, 8'h00, 40, 5, 7);
    chk("mid rst partial valid", 32'(nvalid - v0), 32'd0);
    scan(aloha, 8'h00, 40, 0, 7);
    chk("mid rst full valid", 32'(nvalid - v0), 32'd1);
    chk("mid rst full digits", frame_digits, 32'hFFFA_B0DA);
    v0 = nvalid;
    scan(p7, 8'h00, 40, 0, 7);
    chk("unknown valid count", 32'(nvalid - v0), 32'd1);
    chk("unknown digits", frame_digits, 32'hFFFA_BEDA);
    chk("unknown flag", 32'(frame_unknown), 32'h1);
    scan(aloha, 8'h00, 40, 0, 7);
    chk("unknown cleared", 32'(frame_unknown), 32'h0);
    chk("valid error overlap", 32'(nboth), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
